cmd_issue_queue: RTL and testbench
==================================

Name: cmd_issue_queue

Overview:
- Upstream feeder for the op-code execution stage.
- Buffers {op_code, address, data} commands from a valid/ready producer in a small FIFO.
- Issues one registered command per cycle onto the execution stage's op_code/address/data bus.
- The execution stage evaluates only on an op_code change, so this block inserts a one-cycle NOP (op_code 0) between back-to-back identical op codes to guarantee every command is executed.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- OP_W, 8, op_code width
- ADDR_W, 8, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer command valid
- in_ready  out  1  FIFO can accept; equals (level != DEPTH)
- in_op_code  in  OP_W  command op code
- in_address  in  ADDR_W  command address
- in_data  in  DATA_W  command operand
- stall  in  1  downstream hold; outputs and FIFO head frozen while high
- out_valid  out  1  out_* carries a real command this cycle
- out_op_code  out  OP_W  to execution stage op_code
- out_address  out  ADDR_W  to execution stage address
- out_data  out  DATA_W  to execution stage data
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- drop_cnt  out  16  illegal commands discarded (see optional feature)

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_op_code=0, out_address=0, out_data=0, level=0, drop_cnt=0, rd/wr pointers=0, state=IDLE. A reset mid-stream discards all queued commands.
- Push: in_valid && in_ready at an edge writes the entry at wr_ptr; wr_ptr wraps modulo DEPTH.
- When full, in_ready=0 and in_valid is ignored; no overwrite.
- Pop happens only in the issue path below; rd_ptr wraps modulo DEPTH.
- Level: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop.
- No bypass: a command pushed at edge E reaches out_* at edge E+1 at earliest (1-cycle latency from empty).
- FSM, evaluated each edge while stall=0:
  - IDLE: FIFO empty, or the last cycle drove NOP.
    - Empty: drive NOP (out_valid=0, out_op_code=0; address/data hold).
    - Non-empty: go to ISSUE logic.
  - ISSUE:
    - Head op_code differs from current out_op_code, or out_valid=0: pop the head, register it to out_*, set out_valid=1, stay ISSUE.
    - Head op_code equals out_op_code with out_valid=1: no pop; drive NOP (out_valid=0, out_op_code=0), go to GAP.
    - FIFO empty: drive NOP, go to IDLE.
  - GAP: one NOP cycle complete; next edge issues the head (pop) and returns to ISSUE.
- stall=1: no pop, no state change, all out_* hold. Pushes continue normally.
- stall deasserting resumes exactly where the FSM was held.
- Op code 0 entering the FIFO is legal: it is issued with out_valid=1 and never triggers GAP insertion against a NOP.
- Throughput: 1 command/cycle for alternating op codes; 1 command per 2 cycles for repeated op codes.

Optional Feature:
- Macro: CMD_ISSUE_OPCHECK_EN.
- Defined:
  - A push with in_op_code outside 1..4 is accepted (handshake completes) but not written.
  - drop_cnt increments, saturating at 16'hFFFF.
  - level is unaffected.
- Undefined:
  - All op codes are queued.
  - drop_cnt is tied to 0.

Test Plan:
- Reset mid-stream: push 3 commands, assert rst_n=0 while out_valid=1 -> all outputs 0 immediately, level=0; post-release queue issues nothing.
- Alternating ops: push op 1/2/3/4 with data 0x10,0x20,0x30,0x40 on consecutive cycles, stall=0 -> out_op_code 1,2,3,4 on 4 consecutive cycles starting one cycle after the first push, then NOP.
- Repeat op: push op 2 data 0xA then op 2 data 0xB -> sequence op2/0xA, NOP (op 0, out_valid=0), op2/0xB.
- Full: stall=1, push 5 commands -> first 4 accepted, level=4, in_ready=0 on 5th; release stall -> 4 issued in order, level returns to 0.
- Stall hold: stall=1 while out_op_code=3 for 3 cycles -> out_* constant, no pop, level unchanged apart from concurrent pushes.
- CMD_ISSUE_OPCHECK_EN defined: push ops 7, 1, 0 -> only op 1 issued, drop_cnt=2.

Source files
------------

// File: rtl/cmd_issue_queue.sv
// rtl/cmd_issue_queue.sv - command FIFO feeding the op-code execution stage with NOP gap insertion
// Optional feature: define CMD_ISSUE_OPCHECK_EN to discard pushes whose op code is outside 1..4.
module cmd_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op_code,
  input  logic [ADDR_W-1:0]          in_address,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       stall,
  output logic                       out_valid,
  output logic [OP_W-1:0]            out_op_code,
  output logic [ADDR_W-1:0]          out_address,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [OP_W-1:0]   op_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    state, nxt_state;
  logic          push_req, push, pop, empty, op_ok;
  logic [OP_W-1:0] head_op;

  assign in_ready = (level != LW'(DEPTH));
  assign push_req = in_valid && in_ready;
  assign empty    = (level == '0);
  assign head_op  = op_mem[rd_ptr];

`ifdef CMD_ISSUE_OPCHECK_EN
  assign op_ok = (in_op_code != '0) && (in_op_code <= OP_W'(4));
`else
  assign op_ok = 1'b1;
`endif
  // Rejected op codes still complete the handshake; they just never land in the FIFO.
  assign push = push_req && op_ok;

  always_comb begin
    pop       = 1'b0;
    nxt_state = state;
    if (!stall) begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            nxt_state = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (empty) begin
            nxt_state = S_IDLE;
          end else if (!out_valid || head_op != out_op_code) begin
            pop = 1'b1;
          end else begin
            nxt_state = S_GAP;
          end
        end
        S_GAP: begin
          if (!empty) begin
            pop       = 1'b1;
            nxt_state = S_ISSUE;
          end else begin
            nxt_state = S_IDLE;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= in_op_code;
      addr_mem[wr_ptr] <= in_address;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      state       <= S_IDLE;
      out_valid   <= 1'b0;
      out_op_code <= '0;
      out_address <= '0;
      out_data    <= '0;
    end else begin
      state <= nxt_state;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // NOP keeps address/data so the execution stage sees only the op_code drop to 0.
      if (!stall) begin
        if (pop) begin
          out_valid   <= 1'b1;
          out_op_code <= head_op;
          out_address <= addr_mem[rd_ptr];
          out_data    <= data_mem[rd_ptr];
        end else begin
          out_valid   <= 1'b0;
          out_op_code <= '0;
        end
      end
    end
  end

`ifdef CMD_ISSUE_OPCHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (push_req && !op_ok && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cmd_issue_queue.sv
// tb/tb_cmd_issue_queue.sv - self-checking bench for cmd_issue_queue
module tb_cmd_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_op_code = '0;
  logic [7:0]  in_address = '0;
  logic [31:0] in_data = '0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [7:0]  out_op_code;
  logic [7:0]  out_address;
  logic [31:0] out_data;
  logic [2:0]  level;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad = 0;

  cmd_issue_queue #(.DEPTH(DEPTH), .OP_W(8), .ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op_code(in_op_code), .in_address(in_address), .in_data(in_data),
    .stall(stall),
    .out_valid(out_valid), .out_op_code(out_op_code),
    .out_address(out_address), .out_data(out_data),
    .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        mq[$];
  logic        m_valid;
  logic [7:0]  m_op;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic [15:0] m_drop;

  typedef struct {
    logic        v;
    logic [7:0]  op;
    logic [31:0] d;
    logic        st;
    logic        ev;
    logic [7:0]  eop;
    logic [31:0] ed;
    int          elvl;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_op = 0; m_addr = 0; m_data = 0; m_drop = 0;
  endtask

  // Reference: issue the head unless it repeats the op currently shown as valid; then accept the push.
  task automatic model_step(input logic v, input logic [7:0] op, input logic [7:0] a,
                            input logic [31:0] d, input logic st);
    cmd_t c;
    bit rdy;
    rdy = (mq.size() < DEPTH);
    if (!st) begin
      if (mq.size() > 0 && (!m_valid || mq[0].op != m_op)) begin
        c = mq.pop_front();
        m_valid = 1; m_op = c.op; m_addr = c.a; m_data = c.d;
      end else begin
        m_valid = 0; m_op = 0;
      end
    end
    if (v && rdy) begin
`ifdef CMD_ISSUE_OPCHECK_EN
      if (op < 1 || op > 4) begin
        if (m_drop != 16'hFFFF) m_drop++;
      end else
`endif
      begin
        c.op = op; c.a = a; c.d = d;
        mq.push_back(c);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] op, input logic [7:0] a,
                     input logic [31:0] d, input logic st);
    in_valid = v; in_op_code = op; in_address = a; in_data = d; stall = st;
    @(posedge clk);
    model_step(v, op, a, d, st);
    #1;
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, 8'd0, 8'd0, 32'd0, st);
  endtask

  task automatic do_reset();
    in_valid = 0; stall = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic add_vec(input logic v, input logic [7:0] op, input logic [31:0] d, input logic st,
                         input logic ev, input logic [7:0] eop, input logic [31:0] ed, input int elvl);
    vec_t t;
    t.v = v; t.op = op; t.d = d; t.st = st;
    t.ev = ev; t.eop = eop; t.ed = ed; t.elvl = elvl;
    tbl.push_back(t);
  endtask

  initial begin
    add_vec(1, 1, 32'h10, 0, 0, 0, 32'h0,  1);
    add_vec(1, 2, 32'h20, 0, 1, 1, 32'h10, 1);
    add_vec(1, 3, 32'h30, 0, 1, 2, 32'h20, 1);
    add_vec(1, 4, 32'h40, 0, 1, 3, 32'h30, 1);
    add_vec(0, 0, 32'h0,  0, 1, 4, 32'h40, 0);
    add_vec(0, 0, 32'h0,  0, 0, 0, 32'h40, 0);
    add_vec(1, 2, 32'hA,  0, 0, 0, 32'h40, 1);
    add_vec(1, 2, 32'hB,  0, 1, 2, 32'hA,  1);
    add_vec(0, 0, 32'h0,  0, 0, 0, 32'hA,  1);
    add_vec(0, 0, 32'h0,  0, 1, 2, 32'hB,  0);
    add_vec(0, 0, 32'h0,  0, 0, 0, 32'hB,  0);
`ifndef CMD_ISSUE_OPCHECK_EN
    add_vec(1, 0, 32'h5,  0, 0, 0, 32'hB,  1);
    add_vec(1, 0, 32'h6,  0, 1, 0, 32'h5,  1);
    add_vec(0, 0, 32'h0,  0, 0, 0, 32'h5,  1);
    add_vec(0, 0, 32'h0,  0, 1, 0, 32'h6,  0);
    add_vec(0, 0, 32'h0,  0, 0, 0, 32'h6,  0);
`endif

    model_reset();
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_op", out_op_code, 0);
    check("reset_out_data", out_data, 0);
    check("reset_level", level, 0);
    check("reset_drop", drop_cnt, 0);
    do_reset();

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].op, 8'(tbl[i].d + 1), tbl[i].d, tbl[i].st);
      check($sformatf("vec%0d_valid", i), out_valid, tbl[i].ev);
      check($sformatf("vec%0d_op", i), out_op_code, tbl[i].eop);
      check($sformatf("vec%0d_data", i), out_data, tbl[i].ed);
      check($sformatf("vec%0d_level", i), level, tbl[i].elvl);
      if (tbl[i].ev) check($sformatf("vec%0d_addr", i), out_address, 8'(tbl[i].ed + 1));
    end

    // Full: fill under stall, fifth push refused, then drain in order.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; stall = 1;
      #1;
      check($sformatf("full_ready%0d", i), in_ready, (i < 4));
      cyc(1'b1, 8'((i % 2) + 1), 8'(i), 32'h100 + i, 1'b1);
    end
    check("full_level", level, 4);
    check("full_out_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check($sformatf("drain%0d_op", i), out_op_code, 8'((i % 2) + 1));
      check($sformatf("drain%0d_data", i), out_data, 32'h100 + i);
    end
    idle(1'b0);
    check("drain_level", level, 0);
    check("drain_nop", out_valid, 0);

    // Stall hold while op 3 is on the bus, with one concurrent push.
    cyc(1'b1, 8'd3, 8'h77, 32'h77, 1'b0);
    cyc(1'b1, 8'd4, 8'h88, 32'h88, 1'b0);
    check("hold_pre_op", out_op_code, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(i == 0, 8'd1, 8'h99, 32'h99, 1'b1);
      check($sformatf("hold%0d_op", i), out_op_code, 3);
      check($sformatf("hold%0d_data", i), out_data, 32'h77);
      check($sformatf("hold%0d_valid", i), out_valid, 1);
      check($sformatf("hold%0d_level", i), level, 2);
    end
    idle(1'b0);
    check("resume_op4", out_op_code, 4);
    idle(1'b0);
    check("resume_op1", out_op_code, 1);
    idle(1'b0);
    check("resume_nop", out_valid, 0);

    // Reset asserted asynchronously while a command is on the bus.
    cyc(1'b1, 8'd1, 8'h1, 32'h1, 1'b0);
    cyc(1'b1, 8'd2, 8'h2, 32'h2, 1'b0);
    cyc(1'b1, 8'd3, 8'h3, 32'h3, 1'b0);
    in_valid = 0;
    check("mid_pre_valid", out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_op", out_op_code, 0);
    check("mid_rst_addr", out_address, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_level", level, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check($sformatf("post_rst%0d_valid", i), out_valid, 0);
      check($sformatf("post_rst%0d_level", i), level, 0);
    end

`ifdef CMD_ISSUE_OPCHECK_EN
    do_reset();
    cyc(1'b1, 8'd7, 8'h7, 32'h7, 1'b0);
    cyc(1'b1, 8'd1, 8'h1, 32'h1, 1'b0);
    cyc(1'b1, 8'd0, 8'h0, 32'h0, 1'b0);
    check("opchk_issue_valid", out_valid, 1);
    check("opchk_issue_op", out_op_code, 1);
    idle(1'b0);
    check("opchk_nop", out_valid, 0);
    check("opchk_level", level, 0);
    check("opchk_drop", drop_cnt, 2);
`endif

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic v, st;
      logic [7:0] op;
      logic [31:0] d;
      v  = ($urandom_range(0, 99) < 60);
      st = ($urandom_range(0, 99) < 20);
      op = 8'($urandom_range(0, 4));
      d  = $urandom;
      cyc(v, op, 8'(d >> 8), d, st);
      check("rnd_valid", out_valid, m_valid);
      check("rnd_op", out_op_code, m_op);
      check("rnd_addr", out_address, m_addr);
      check("rnd_data", out_data, m_data);
      check("rnd_level", level, mq.size());
      check("rnd_ready", in_ready, mq.size() < DEPTH);
      check("rnd_drop", drop_cnt, m_drop);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
